// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   Word aligner and decoder for one TMDS data channel. Scans the deserialized
//   10-bit words for a run of control tokens. If none turns up in time, it asks
//   the deserializer for a bit slip. Once locked, it decodes data and control
//   tokens. All outputs are registered, so there is one cycle of latency.
//
// Ports
//   clk       in   pixel clock (deserializer parallel domain)
//   Rst       in   asynchronous active-low reset
//   Raw_Data  in   10-bit deserialized word, bit 0 received first
//   Bitslip   out  one-cycle request to shift deserializer alignment by one bit
//   Aligned   out  high while locked
//   Data      out  decoded pixel byte (0 for control tokens / when unlocked)
//   VDE       out  high when Data carries a data token
//   C0, C1    out  control bits, held across data tokens
//   Err_Cnt   out  (TMDS_DEC_ERR_EN only) saturating count of bit slips plus
//                  lock losses
//
// Build option: define TMDS_DEC_ERR_EN to add the Err_Cnt port and counter.

module tmds_channel_decoder #(
  parameter int unsigned CTRL_RUN   = 32,
  parameter int unsigned SEARCH_LEN = 4096,
  parameter int unsigned SLIP_WAIT  = 8,
  parameter int unsigned LOSS_LEN   = 4096
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [9:0]  Raw_Data,
  output logic        Bitslip,
  output logic        Aligned,
  output logic [7:0]  Data,
  output logic        VDE,
  output logic        C0,
  output logic        C1
`ifdef TMDS_DEC_ERR_EN
  ,
  output logic [15:0] Err_Cnt
`endif
);

  localparam int unsigned RunW    = (CTRL_RUN   > 1) ? $clog2(CTRL_RUN)   : 1;
  localparam int unsigned SearchW = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;
  localparam int unsigned WaitW   = (SLIP_WAIT  > 1) ? $clog2(SLIP_WAIT)  : 1;
  localparam int unsigned LossW   = (LOSS_LEN   > 1) ? $clog2(LOSS_LEN)   : 1;

  localparam logic [RunW-1:0]    RunLast    = RunW'(CTRL_RUN - 1);
  localparam logic [SearchW-1:0] SearchLast = SearchW'(SEARCH_LEN - 1);
  localparam logic [WaitW-1:0]   WaitLast   = WaitW'(SLIP_WAIT - 1);
  localparam logic [LossW-1:0]   LossLast   = LossW'(LOSS_LEN - 1);

  typedef enum logic [1:0] {StSearch, StSlip, StLocked} state_e;

  state_e             state_q;
  logic [RunW-1:0]    run_cnt_q;
  logic [SearchW-1:0] search_cnt_q;
  logic [WaitW-1:0]   wait_cnt_q;
  logic [LossW-1:0]   loss_cnt_q;
  logic               bitslip_q, aligned_q, vde_q;
  logic [1:0]         ctrl_q;
  logic [7:0]         data_q;

  logic       is_ctrl;
  logic [1:0] ctrl_val;
  logic [7:0] d, dec;
  logic       lock_hit, timeout, loss;

  // Token classification and data decode of the current input word
  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    unique case (Raw_Data)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase

    d      = Raw_Data[9] ? ~Raw_Data[7:0] : Raw_Data[7:0];
    dec    = 8'h00;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = Raw_Data[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // The counters compare against limit-1 using the current sample. The event
  // therefore fires on the limit-th sample without needing an extra counter bit.
  always_comb begin
    lock_hit = (state_q == StSearch) && is_ctrl && (run_cnt_q == RunLast);
    timeout  = (state_q == StSearch) && !lock_hit && (search_cnt_q == SearchLast);
    loss     = (state_q == StLocked) && !is_ctrl && (loss_cnt_q == LossLast);
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= StSearch;
      run_cnt_q    <= '0;
      search_cnt_q <= '0;
      wait_cnt_q   <= '0;
      loss_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      vde_q        <= 1'b0;
      ctrl_q       <= 2'b00;
      data_q       <= 8'h00;
    end else begin
      bitslip_q <= 1'b0;
      unique case (state_q)
        StSearch: begin
          if (lock_hit) begin
            state_q      <= StLocked;
            aligned_q    <= 1'b1;
            run_cnt_q    <= '0;
            search_cnt_q <= '0;
            loss_cnt_q   <= '0;
            vde_q        <= 1'b0;
            data_q       <= 8'h00;
            ctrl_q       <= ctrl_val;
          end else if (timeout) begin
            state_q      <= StSlip;
            bitslip_q    <= 1'b1;
            run_cnt_q    <= '0;
            search_cnt_q <= '0;
            wait_cnt_q   <= '0;
          end else begin
            if (!is_ctrl) begin
              run_cnt_q <= '0;
            end else if (run_cnt_q != RunLast) begin
              run_cnt_q <= run_cnt_q + RunW'(1);
            end
            if (search_cnt_q != SearchLast) begin
              search_cnt_q <= search_cnt_q + SearchW'(1);
            end
          end
        end
        StSlip: begin
          if (wait_cnt_q == WaitLast) begin
            state_q    <= StSearch;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StLocked: begin
          if (loss) begin
            state_q    <= StSearch;
            aligned_q  <= 1'b0;
            loss_cnt_q <= '0;
            vde_q      <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
          end else if (is_ctrl) begin
            loss_cnt_q <= '0;
            vde_q      <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= ctrl_val;
          end else begin
            loss_cnt_q <= loss_cnt_q + LossW'(1);
            vde_q      <= 1'b1;
            data_q     <= dec;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

`ifdef TMDS_DEC_ERR_EN
  logic [15:0] err_cnt_q;

  // Counts in step with the Bitslip pulse and with the Aligned fall
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      err_cnt_q <= 16'h0000;
    end else if ((timeout || loss) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign Err_Cnt = err_cnt_q;
`endif

  assign Bitslip = bitslip_q;
  assign Aligned = aligned_q;
  assign Data    = data_q;
  assign VDE     = vde_q;
  assign C0      = ctrl_q[0];
  assign C1      = ctrl_q[1];

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder with default parameters.
module tb_tmds_channel_decoder;

  logic        clk = 1'b0;
  logic        Rst;
  logic [9:0]  Raw_Data;
  logic        Bitslip, Aligned, VDE, C0, C1;
  logic [7:0]  Data;
`ifdef TMDS_DEC_ERR_EN
  logic [15:0] Err_Cnt;
`endif

  tmds_channel_decoder dut (
    .clk      (clk),
    .Rst      (Rst),
    .Raw_Data (Raw_Data),
    .Bitslip  (Bitslip),
    .Aligned  (Aligned),
    .Data     (Data),
    .VDE      (VDE),
    .C0       (C0),
    .C1       (C1)
`ifdef TMDS_DEC_ERR_EN
    ,
    .Err_Cnt  (Err_Cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [9:0] Ctrl00 = 10'b1101010100;
  localparam logic [9:0] Ctrl01 = 10'b0010101011;
  localparam logic [9:0] Ctrl10 = 10'b0101010100;
  localparam logic [9:0] Ctrl11 = 10'b1010101011;

  int vectors     = 0;
  int miscompares = 0;

  // {Bitslip, Aligned, VDE, C1, C0, Data}
  logic [12:0] outs;
  assign outs = {Bitslip, Aligned, VDE, C1, C0, Data};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a word, let the DUT sample it, then settle 1 time unit past the edge
  task automatic drive(input logic [9:0] w);
    Raw_Data = w;
    @(posedge clk);
    #1;
  endtask

  logic [19:0] dbl;
  int step, pulses, lock_step, k;
  int p [3];

  initial begin
    Rst      = 1'b0;
    Raw_Data = 10'h000;

    // Held in reset with random input: everything stays zero
    for (int i = 0; i < 16; i++) begin
      drive(10'($urandom));
      check("reset_outs", {3'b000, outs}, 16'h0000);
    end
    #2 Rst = 1'b1;

    // Lock on the 32nd consecutive control token
    for (int i = 0; i < 31; i++) drive(Ctrl00);
    check("no_lock_31", {15'h0, Aligned}, 16'h0000);
    drive(Ctrl00);
    check("lock_32", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00});
    drive(10'h100);
    check("data_100", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00});

    // Control 11, then data held with C1:C0 = 11
    drive(Ctrl11);
    check("ctrl_11", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b0, 2'b11, 8'h00});
    drive(10'h1FF);
    check("data_1ff", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b1, 2'b11, 8'h01});
    drive(Ctrl01);
    check("ctrl_01", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b0, 2'b01, 8'h00});
    drive(Ctrl10);
    check("ctrl_10", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b0, 2'b10, 8'h00});
    drive(10'h2FF);
    check("data_2ff", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b1, 2'b10, 8'hFE});
    drive(10'h155);
    check("data_155", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b1, 2'b10, 8'hFF});
    drive(10'h0AA);
    check("data_0aa", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b1, 2'b10, 8'h00});

    // Reset asserted mid-lock clears outputs without waiting for a clock
    Rst = 1'b0;
    #1;
    check("async_reset", {3'b000, outs}, 16'h0000);
    #2 Rst = 1'b1;

    // A data token breaks the run; lock only after 32 fresh tokens
    for (int i = 0; i < 31; i++) drive(Ctrl00);
    drive(10'h1FF);
    check("broken_run", {15'h0, Aligned}, 16'h0000);
    for (int i = 0; i < 31; i++) drive(Ctrl00);
    check("no_lock_63", {15'h0, Aligned}, 16'h0000);
    drive(Ctrl00);
    check("lock_64", {15'h0, Aligned}, 16'h0001);

    // Loss after 4096 consecutive data tokens, no bit slip on loss
    for (int i = 0; i < 4095; i++) drive(10'h100);
    check("pre_loss", {3'b000, outs}, {3'b000, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00});
    drive(10'h100);
    check("loss", {3'b000, outs}, 16'h0000);
    drive(10'h100);
    check("no_slip_loss", {15'h0, Bitslip}, 16'h0000);
`ifdef TMDS_DEC_ERR_EN
    check("err_after_loss", Err_Cnt, 16'd1);
`endif

    // Slip search: deserializer model starts 3 bits off the token boundary
    Rst = 1'b0;
    #1 Rst = 1'b1;
    dbl       = {Ctrl00, Ctrl00};
    k         = 3;
    step      = 0;
    pulses    = 0;
    lock_step = -1;
    while (step < 13000 && lock_step < 0) begin
      drive(10'(dbl >> k));
      step++;
      if (Bitslip) begin
        if (pulses < 3) p[pulses] = step;
        pulses++;
        k = (k == 0) ? 9 : k - 1;
      end
      if (Aligned) lock_step = step;
    end
    check("slip_pulses", 16'(pulses), 16'd3);
    check("slip_first", 16'(p[0]), 16'd4096);
    check("slip_gap1", 16'(p[1] - p[0]), 16'd4104);
    check("slip_gap2", 16'(p[2] - p[1]), 16'd4104);
    check("slip_lock", 16'(lock_step), 16'd12344);
`ifdef TMDS_DEC_ERR_EN
    check("err_after_slips", Err_Cnt, 16'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
